gpu_pio: RTL and testbench
==========================

# gpu_pio

Parametrised Avalon-MM parallel I/O peripheral for the FPGA fabric. It replaces the fixed-width button, dipswitch and LED PIOs with one generalised block. It adds:
- input synchronisation and per-channel debounce,
- rising/falling edge capture with an interrupt mask,
- atomic set/clear of output bits.

Multiple instances hang off the HPS lightweight bridge: one per button bank, switch bank or LED bank.

## Interface
- IN_WIDTH, 4: number of input channels, 1..32.
- OUT_WIDTH, 7: number of output channels, 1..32.
- DEBOUNCE_CYCLES, 1: consecutive stable cycles required before an input change is accepted, 1..2^20.
- OUT_RESET, 0: reset value of the output register, OUT_WIDTH bits.
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, fixed latency 1, no waitrequest.
- irq  out  1  level interrupt = |(edge_capture & irq_mask).
- in_port  in  IN_WIDTH  asynchronous external inputs.
- out_port  out  OUT_WIDTH  registered outputs.

## Operation
- Register map (word addresses). Unused high bits read 0. Writes to read-only registers are ignored.
  - 0 DATA: read returns the debounced inputs; write loads the output register.
  - 1 OUT: read/write the output register.
  - 2 IRQ_MASK: read/write, IN_WIDTH bits.
  - 3 EDGE_CAPTURE: read; write-1-to-clear.
  - 4 OUT_SET: write-only; out |= wdata.
  - 5 OUT_CLR: write-only; out &= ~wdata.
  - 6 RISE_EN: read/write, IN_WIDTH bits.
  - 7 FALL_EN: read/write, IN_WIDTH bits.
- Input path, per channel:
  - Two-flop synchroniser s1 -> s2, then a debounce counter cnt of width clog2(DEBOUNCE_CYCLES).
  - If s2 == deb, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, then deb <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s2 never reaches deb.
- Edge capture:
  - A rise event is deb 0->1 with RISE_EN set; a fall event is deb 1->0 with FALL_EN set.
  - An event sets the EDGE_CAPTURE bit the cycle after deb changes.
  - A set bit stays set until software writes 1 to it.
  - If a clear and an event for the same bit occur in the same cycle, the event wins and the bit stays 1.
  - Changing RISE_EN/FALL_EN never clears captured bits.
- Output path:
  - out_port is driven directly from the output register; no combinational path from the bus.
  - Writes to OUT_SET and OUT_CLR operate on the current value, so two back-to-back writes compose correctly.
- Read and write strobes asserted in the same cycle: both are performed. The read returns pre-write contents.

## Timing
- Reset values: out_port = OUT_RESET. avs_readdata, irq, IRQ_MASK, EDGE_CAPTURE, RISE_EN, FALL_EN, s1, s2, deb and cnt are all 0.
- Reset is asynchronous assert, synchronous deassert; the deassert is handled by the system reset controller.
- Reset asserted mid-debounce discards the count. Captured edges and masks are lost.
- Input latency: in_port changes and is sampled at edge t. Then:
  - deb updates at edge t+1+DEBOUNCE_CYCLES.
  - EDGE_CAPTURE and irq update at edge t+2+DEBOUNCE_CYCLES.
- Read latency: avs_readdata is valid the cycle after avs_read. It holds its value when avs_read is low.
- Write latency: the register updates at the same edge as avs_write. out_port changes that edge.
- irq is registered-equivalent: it is a combinational AND/OR of registers only. It deasserts the edge after the clearing write or mask write.
- Inputs held high through reset: deb rises after reset and produces a rise event. No bit is captured because RISE_EN resets to 0.

## Test plan
- Reset with OUT_RESET=7'h55 -> out_port=7'h55, irq=0, all readable registers read 0 except OUT=0x55.
- OUT_SET 0x0F then OUT_CLR 0x05 on consecutive cycles, starting from 0x00 -> out_port 0x0F then 0x0A; a read of OUT returns 0x0A.
- DEBOUNCE_CYCLES=4:
  - 3-cycle pulse on in_port[0] -> DATA stays 0, no edge captured.
  - 5-cycle-stable high -> DATA bit0=1 exactly 5 cycles after the sampling edge.
- RISE_EN=0x1, FALL_EN=0x2, IRQ_MASK=0x3:
  - Toggle in[0] and in[1] high then low -> EDGE_CAPTURE=0x3 and irq=1.
  - Write 0x1 to EDGE_CAPTURE -> reads 0x2, irq remains 1.
  - Write IRQ_MASK=0 -> irq=0.
- A write-1-clear of bit0 in the same cycle as a new rise event on bit0 -> EDGE_CAPTURE bit0 reads 1.
- Assert reset while cnt is mid-count and EDGE_CAPTURE=0xF -> all state is 0 immediately without a clock edge; no edge is reported after release with enables at 0.

Source files
------------

// File: rtl/gpu_pio.sv
// gpu_pio: parametrised Avalon-MM parallel I/O peripheral.
// Synchronises and debounces IN_WIDTH inputs, captures rising/falling edges
// under per-channel enables, raises a masked level interrupt, and drives
// OUT_WIDTH registered outputs with load / atomic set / atomic clear.
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   avs_address         - 3-bit word address
//   avs_read/avs_write  - bus strobes (may be asserted together)
//   avs_writedata       - 32-bit write data
//   avs_readdata        - 32-bit read data, valid the cycle after avs_read
//   irq                 - |(edge_capture & irq_mask)
//   in_port             - asynchronous external inputs
//   out_port            - registered outputs
module gpu_pio #(
  parameter int unsigned          IN_WIDTH        = 4,
  parameter int unsigned          OUT_WIDTH       = 7,
  parameter int unsigned          DEBOUNCE_CYCLES = 1,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port
);

  // A single-cycle debounce still needs a 1-bit counter to keep the types legal.
  localparam int unsigned    CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_OUT  = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_EDGE = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;
  localparam logic [2:0] A_RISE = 3'd6;
  localparam logic [2:0] A_FALL = 3'd7;

  logic [IN_WIDTH-1:0]  s1, s2, deb, deb_q;
  logic [CNT_W-1:0]     cnt [IN_WIDTH];
  logic [IN_WIDTH-1:0]  irq_mask, edge_cap, rise_en, fall_en;
  logic [OUT_WIDTH-1:0] out_reg;

  logic [IN_WIDTH-1:0]  rise_ev, fall_ev, ec_clr, ec_next;
  logic [OUT_WIDTH-1:0] out_next;
  logic [31:0]          rd_mux;
  logic                 unused_wdata;

  // Writedata bits above both register widths are don't-care.
  assign unused_wdata = ^avs_writedata;

  // Events come from the registered debounced value and its one-cycle delay.
  assign rise_ev = deb & ~deb_q & rise_en;
  assign fall_ev = ~deb & deb_q & fall_en;

  // Next-state for output and capture registers, plus the read mux.
  always_comb begin
    out_next = out_reg;
    ec_clr   = '0;
    rd_mux   = '0;
    if (avs_write) begin
      case (avs_address)
        A_DATA, A_OUT: out_next = avs_writedata[OUT_WIDTH-1:0];
        A_SET:         out_next = out_reg | avs_writedata[OUT_WIDTH-1:0];
        A_CLR:         out_next = out_reg & ~avs_writedata[OUT_WIDTH-1:0];
        A_EDGE:        ec_clr   = avs_writedata[IN_WIDTH-1:0];
        default:       ;
      endcase
    end
    // New events override a same-cycle write-1-to-clear.
    ec_next = (edge_cap & ~ec_clr) | rise_ev | fall_ev;
    case (avs_address)
      A_DATA:  rd_mux = 32'(deb);
      A_OUT:   rd_mux = 32'(out_reg);
      A_MASK:  rd_mux = 32'(irq_mask);
      A_EDGE:  rd_mux = 32'(edge_cap);
      A_RISE:  rd_mux = 32'(rise_en);
      A_FALL:  rd_mux = 32'(fall_en);
      default: rd_mux = '0;
    endcase
  end

  // Input synchroniser and per-channel debounce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < int'(IN_WIDTH); i++) cnt[i] <= '0;
    end else begin
      s1    <= in_port;
      s2    <= s1;
      deb_q <= deb;
      for (int i = 0; i < int'(IN_WIDTH); i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Control/status registers and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg      <= OUT_RESET;
      irq_mask     <= '0;
      edge_cap     <= '0;
      rise_en      <= '0;
      fall_en      <= '0;
      avs_readdata <= '0;
    end else begin
      out_reg  <= out_next;
      edge_cap <= ec_next;
      if (avs_write) begin
        case (avs_address)
          A_MASK:  irq_mask <= avs_writedata[IN_WIDTH-1:0];
          A_RISE:  rise_en  <= avs_writedata[IN_WIDTH-1:0];
          A_FALL:  fall_en  <= avs_writedata[IN_WIDTH-1:0];
          default: ;
        endcase
      end
      // Read samples pre-write contents; readdata holds when not reading.
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

  assign irq      = |(edge_cap & irq_mask);
  assign out_port = out_reg;

endmodule

// File: tb/tb_gpu_pio.sv
// tb_gpu_pio: directed, table-driven self-checking bench for gpu_pio
// (IN_WIDTH=4, OUT_WIDTH=7, DEBOUNCE_CYCLES=4, OUT_RESET=7'h55).
module tb_gpu_pio;

  logic        clk;
  logic        reset;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [3:0]  in_port;
  logic [6:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;

  gpu_pio #(
    .IN_WIDTH(4), .OUT_WIDTH(7), .DEBOUNCE_CYCLES(4), .OUT_RESET(7'h55)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .in_port(in_port), .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra;
    logic [31:0] er;
    logic [6:0]  eo;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_read = 1'b1; avs_address = a;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_rst [8];
    logic        seen_d, seen_i;

    tbl[0]  = '{3'd1, 32'hFFFF_FFFF, 3'd1, 32'h7F, 7'h7F};
    tbl[1]  = '{3'd0, 32'h0000_0012, 3'd1, 32'h12, 7'h12};
    tbl[2]  = '{3'd4, 32'h0000_0041, 3'd1, 32'h53, 7'h53};
    tbl[3]  = '{3'd5, 32'h0000_0003, 3'd1, 32'h50, 7'h50};
    tbl[4]  = '{3'd2, 32'hFFFF_FFF6, 3'd2, 32'h06, 7'h50};
    tbl[5]  = '{3'd6, 32'h0000_000A, 3'd6, 32'h0A, 7'h50};
    tbl[6]  = '{3'd7, 32'h0000_0005, 3'd7, 32'h05, 7'h50};
    tbl[7]  = '{3'd4, 32'h0000_0000, 3'd4, 32'h00, 7'h50};
    tbl[8]  = '{3'd3, 32'h0000_000F, 3'd3, 32'h00, 7'h50};
    tbl[9]  = '{3'd0, 32'h0000_0000, 3'd0, 32'h00, 7'h00};
    tbl[10] = '{3'd2, 32'h0000_0000, 3'd2, 32'h00, 7'h00};
    tbl[11] = '{3'd6, 32'h0000_0000, 3'd6, 32'h00, 7'h00};
    tbl[12] = '{3'd7, 32'h0000_0000, 3'd7, 32'h00, 7'h00};
    tbl[13] = '{3'd5, 32'h0000_007F, 3'd5, 32'h00, 7'h00};
    exp_rst = '{32'h0, 32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; in_port = '0;

    // Reset state
    #3;
    check("rst_out_port", 32'(out_port), 32'h55);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      check($sformatf("rst_reg%0d", a), rd, exp_rst[a]);
    end

    // Register map vectors
    for (int i = 0; i < 14; i++) begin
      bus_write(tbl[i].wa, tbl[i].wd);
      check($sformatf("vec%0d_out_port", i), 32'(out_port), 32'(tbl[i].eo));
      bus_read(tbl[i].ra, rd);
      check($sformatf("vec%0d_read", i), rd, tbl[i].er);
    end

    // Back-to-back OUT_SET then OUT_CLR from 0x00
    @(negedge clk);
    avs_write = 1'b1; avs_address = 3'd4; avs_writedata = 32'h0F;
    @(negedge clk);
    check("set_out_port", 32'(out_port), 32'h0F);
    avs_address = 3'd5; avs_writedata = 32'h05;
    @(negedge clk);
    avs_write = 1'b0;
    check("clr_out_port", 32'(out_port), 32'h0A);
    bus_read(3'd1, rd);
    check("setclr_read_out", rd, 32'h0A);

    // readdata holds while avs_read is low
    avs_address = 3'd2;
    repeat (3) @(negedge clk);
    check("readdata_hold", avs_readdata, 32'h0A);

    // Simultaneous read and write returns pre-write contents
    @(negedge clk);
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 3'd1; avs_writedata = 32'h33;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    check("rw_same_read", avs_readdata, 32'h0A);
    check("rw_same_out", 32'(out_port), 32'h33);

    // 3-cycle glitch on in[0] is rejected
    bus_write(3'd6, 32'h1);
    bus_write(3'd2, 32'h1);
    @(negedge clk);
    in_port = 4'h1;
    repeat (3) @(negedge clk);
    in_port = 4'h0;
    avs_read = 1'b1; avs_address = 3'd0;
    seen_d = 1'b0; seen_i = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen_d = seen_d | avs_readdata[0];
      seen_i = seen_i | irq;
    end
    avs_read = 1'b0;
    check("glitch_data", 32'(seen_d), 32'h0);
    check("glitch_irq", 32'(seen_i), 32'h0);
    bus_read(3'd3, rd);
    check("glitch_edge", rd, 32'h0);

    // Stable high: deb at t+5, capture/irq at t+6
    @(negedge clk);
    avs_read = 1'b1; avs_address = 3'd0; in_port = 4'h1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        check("lat_data_t5", avs_readdata, 32'h0);
        check("lat_irq_t5", 32'(irq), 32'h0);
      end
      if (k == 7) begin
        check("lat_data_t6", avs_readdata, 32'h1);
        check("lat_irq_t6", 32'(irq), 32'h1);
      end
    end
    avs_read = 1'b0;
    in_port = 4'h0;
    repeat (8) @(negedge clk);
    bus_write(3'd3, 32'hF);
    bus_read(3'd3, rd);
    check("w1c_all", rd, 32'h0);
    check("w1c_all_irq", 32'(irq), 32'h0);

    // Rise on bit0, fall on bit1
    bus_write(3'd6, 32'h1);
    bus_write(3'd7, 32'h2);
    bus_write(3'd2, 32'h3);
    @(negedge clk);
    in_port = 4'h3;
    repeat (8) @(negedge clk);
    in_port = 4'h0;
    repeat (8) @(negedge clk);
    bus_read(3'd3, rd);
    check("edge_both", rd, 32'h3);
    check("edge_both_irq", 32'(irq), 32'h1);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd);
    check("edge_clr0", rd, 32'h2);
    check("edge_clr0_irq", 32'(irq), 32'h1);
    bus_write(3'd2, 32'h0);
    check("mask0_irq", 32'(irq), 32'h0);

    // Write-1-clear collides with a new rise on bit0: event wins
    @(negedge clk);
    in_port = 4'h1;
    repeat (6) @(negedge clk);
    avs_write = 1'b1; avs_address = 3'd3; avs_writedata = 32'h1;
    @(negedge clk);
    avs_write = 1'b0;
    bus_read(3'd3, rd);
    check("collide_edge", rd, 32'h3);

    // Reset mid-debounce with all edges captured
    bus_write(3'd6, 32'hF);
    bus_write(3'd7, 32'hF);
    bus_write(3'd2, 32'hF);
    bus_write(3'd1, 32'h2A);
    @(negedge clk);
    in_port = 4'hE;
    repeat (8) @(negedge clk);
    bus_read(3'd3, rd);
    check("pre_rst_edge", rd, 32'hF);
    check("pre_rst_irq", 32'(irq), 32'h1);
    in_port = 4'h1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out", 32'(out_port), 32'h55);
    check("async_rst_irq", 32'(irq), 32'h0);
    check("async_rst_rdata", avs_readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(3'd3, rd);
    check("post_rst_edge", rd, 32'h0);
    bus_read(3'd0, rd);
    check("post_rst_data", rd, 32'h1);
    bus_read(3'd2, rd);
    check("post_rst_mask", rd, 32'h0);
    check("post_rst_irq", 32'(irq), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
